// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: address/data word types,
// the refill block width, and boolean/null constants.
// No ports; imported by the cache RTL.
package icache_pkg;

    typedef logic [31:0] ADDR_TYPE;
    typedef logic [31:0] DATA_TYPE;

    localparam int ICACHE_INST_BLOCK_SIZE = 128;

    localparam logic     TRUE  = 1'b1;
    localparam logic     FALSE = 1'b0;
    localparam ADDR_TYPE NULL  = '0;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// Latency/backpressure: none here; the fetcher holds a request until it sees
// finish_sign_to_fch, and the memory controller buffers single refill pulses.
// Ports: slave = cache side, master = fetcher/memory-controller side.
interface icache_if #(
    parameter int BLOCK_BITS = 128
);
    logic [31:0]           pc_from_fch;
    logic                  enable_sign_from_fch;
    logic                  rollback_sign_from_fch;
    logic                  finish_sign_to_fch;
    logic [31:0]           inst_to_fch;
    logic                  enable_sign_to_mem;
    logic [31:0]           pc_to_mem;
    logic                  finish_sign_from_mem;
    logic [BLOCK_BITS-1:0] inst_block_from_mem;

    modport slave (
        input  pc_from_fch, enable_sign_from_fch, rollback_sign_from_fch,
        input  finish_sign_from_mem, inst_block_from_mem,
        output finish_sign_to_fch, inst_to_fch, enable_sign_to_mem, pc_to_mem
    );

    modport master (
        output pc_from_fch, enable_sign_from_fch, rollback_sign_from_fch,
        output finish_sign_from_mem, inst_block_from_mem,
        input  finish_sign_to_fch, inst_to_fch, enable_sign_to_mem, pc_to_mem
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, one outstanding miss, 16-byte lines.
// Latency: hit 1 cycle; miss = memory latency + 2 cycles after the refill pulse.
// Backpressure: rdy=0 freezes everything; requests outside IDLE are ignored.
// Ports: clk, rst (sync, active-high), rdy (run enable), bus (icache_if.slave).
module icache
    import icache_pkg::*;
#(
    parameter int LINE_NUM   = 32,
    parameter int BLOCK_BITS = ICACHE_INST_BLOCK_SIZE
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  bus
);

    localparam int IDX_W = $clog2(LINE_NUM);
    localparam int TAG_W = 32 - 4 - IDX_W;

    typedef enum logic [1:0] {IDLE, MISS, WAIT_MEM, REFILL} state_e;

    state_e                 state_q, state_d;
    ADDR_TYPE               pc_q, pc_d;
    logic                   fin_q, fin_d;
    DATA_TYPE               inst_q, inst_d;
    logic                   mem_en_q, mem_en_d;
    ADDR_TYPE               pc_mem_q, pc_mem_d;

    logic [LINE_NUM-1:0]    valid_q;
    logic [TAG_W-1:0]       tag_q  [LINE_NUM];
    logic [BLOCK_BITS-1:0]  data_q [LINE_NUM];

    // Lookup of the incoming fetch address
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    DATA_TYPE         hit_word;
    // Lookup of the latched (missing) address
    logic [IDX_W-1:0] lat_idx;
    DATA_TYPE         lat_word;
    logic             fill_en;
    logic             unused_pc_bits;

    assign req_idx  = bus.pc_from_fch[4 +: IDX_W];
    assign req_tag  = bus.pc_from_fch[31 -: TAG_W];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign hit_word = data_q[req_idx][{bus.pc_from_fch[3:2], 5'b0} +: 32];
    assign lat_idx  = pc_q[4 +: IDX_W];
    assign lat_word = data_q[lat_idx][{pc_q[3:2], 5'b0} +: 32];

    // Byte offset within a word is irrelevant to an instruction fetch
    assign unused_pc_bits = ^{pc_q[1:0], bus.pc_from_fch[1:0]};

    // A rollback in the same cycle as the memory return discards the line
    assign fill_en = rdy && (state_q == WAIT_MEM) && bus.finish_sign_from_mem
                     && !bus.rollback_sign_from_fch;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= NULL;
            fin_q    <= FALSE;
            inst_q   <= '0;
            mem_en_q <= FALSE;
            pc_mem_q <= NULL;
            valid_q  <= '0;
        end else if (rdy) begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            fin_q    <= fin_d;
            inst_q   <= inst_d;
            mem_en_q <= mem_en_d;
            pc_mem_q <= pc_mem_d;
            if (fill_en) valid_q[lat_idx] <= TRUE;
        end
    end

    // Tag/data arrays carry no reset; valid bits alone gate hits
    always_ff @(posedge clk) begin
        if (!rst && fill_en) begin
            tag_q[lat_idx]  <= pc_q[31 -: TAG_W];
            data_q[lat_idx] <= bus.inst_block_from_mem;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (bus.rollback_sign_from_fch) begin
            state_d = IDLE;
            pc_d    = NULL;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.enable_sign_from_fch && !hit) begin
                        pc_d    = bus.pc_from_fch;
                        state_d = MISS;
                    end
                end
                MISS:     state_d = WAIT_MEM;
                WAIT_MEM: if (bus.finish_sign_from_mem) state_d = REFILL;
                REFILL:   state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    // Output logic: pulses default low, data outputs hold their last value
    always_comb begin
        fin_d    = FALSE;
        inst_d   = inst_q;
        mem_en_d = FALSE;
        pc_mem_d = pc_mem_q;
        if (!bus.rollback_sign_from_fch) begin
            case (state_q)
                IDLE: begin
                    if (bus.enable_sign_from_fch && hit) begin
                        fin_d  = TRUE;
                        inst_d = hit_word;
                    end
                end
                MISS: begin
                    mem_en_d = TRUE;
                    pc_mem_d = {pc_q[31:4], 4'b0};
                end
                REFILL: begin
                    fin_d  = TRUE;
                    inst_d = lat_word;
                end
                default: ;
            endcase
        end
    end

    assign bus.finish_sign_to_fch = fin_q;
    assign bus.inst_to_fch        = inst_q;
    assign bus.enable_sign_to_mem = mem_en_q;
    assign bus.pc_to_mem          = pc_mem_q;

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache (LINE_NUM=32, 128-bit lines).
// Reference: per-index valid/tag table plus a lazily filled memory image.
module tb_icache;

    logic clk;
    logic rst;
    logic rdy;
    int   n_cmp;
    int   n_err;

    icache_if #(.BLOCK_BITS(128)) bus ();

    icache #(.LINE_NUM(32), .BLOCK_BITS(128)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit           mv [32];
    logic [22:0]  mt [32];
    logic [127:0] mem [logic [27:0]];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic get_block(input logic [27:0] key, output logic [127:0] blk);
        if (!mem.exists(key))
            mem[key] = {$urandom(), $urandom(), $urandom(), $urandom()};
        blk = mem[key];
    endtask

    // mode: 0 plain fetch, 1 rollback in WAIT_MEM then late memory return,
    // 2 rollback together with memory return, 3 rdy low 5 cycles in WAIT_MEM
    task automatic fetch(input logic [31:0] pc, input int lat, input int mode_i);
        int           mode, idx, k, en_cnt, fin_cnt, fin_c, e, mem_due;
        bit           exp_hit;
        logic [22:0]  tg;
        logic [127:0] blk;
        logic [31:0]  exp_word;
        idx     = int'(pc[8:4]);
        tg      = pc[31:9];
        exp_hit = mv[idx] && (mt[idx] == tg);
        mode    = exp_hit ? 0 : mode_i;
        get_block(pc[31:4], blk);
        k        = int'(pc[3:2]);
        exp_word = blk[k*32 +: 32];
        en_cnt = 0; fin_cnt = 0; fin_c = -1; e = -100; mem_due = -1;
        bus.pc_from_fch          = pc;
        bus.enable_sign_from_fch = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            bus.finish_sign_from_mem   = 1'b0;
            bus.rollback_sign_from_fch = 1'b0;
            if (bus.enable_sign_to_mem) begin
                en_cnt++;
                e = c;
                check("pc_to_mem", bus.pc_to_mem, {pc[31:4], 4'h0});
                mem_due = (mode == 3) ? c + 7 : c + lat;
            end
            if (bus.finish_sign_to_fch) begin
                fin_cnt++;
                if (fin_c < 0) fin_c = c;
                check("inst", bus.inst_to_fch, exp_word);
                bus.enable_sign_from_fch = 1'b0;
            end
            if (mode == 1 && c == e) begin
                bus.rollback_sign_from_fch = 1'b1;
                bus.enable_sign_from_fch   = 1'b0;
            end
            if (mode == 1 && c == e + 1) begin
                bus.finish_sign_from_mem = 1'b1;
                bus.inst_block_from_mem  = blk;
            end
            if (mode == 2 && c == e) begin
                bus.rollback_sign_from_fch = 1'b1;
                bus.finish_sign_from_mem   = 1'b1;
                bus.inst_block_from_mem    = blk;
                bus.enable_sign_from_fch   = 1'b0;
            end
            if (mode == 3 && c >= e + 1 && c <= e + 5) begin
                rdy = 1'b0;
                if ((c - e) % 2 == 1) begin
                    bus.finish_sign_from_mem = 1'b1;
                    bus.inst_block_from_mem  = ~blk;
                end
            end
            if (mode == 3 && c == e + 6) rdy = 1'b1;
            if ((mode == 0 || mode == 3) && c == mem_due) begin
                bus.finish_sign_from_mem = 1'b1;
                bus.inst_block_from_mem  = blk;
            end
            if (fin_c > 0 && c == fin_c + 1) break;
            if ((mode == 1 || mode == 2) && c == e + 8) break;
        end
        check("miss_req", en_cnt, exp_hit ? 0 : 1);
        if (mode == 1 || mode == 2) begin
            check("rb_fin", fin_cnt, 0);
        end else begin
            check("fin_cnt", fin_cnt, 1);
            check("latency", fin_c, exp_hit ? 1 : mem_due + 2);
            if (!exp_hit) begin
                mv[idx] = 1'b1;
                mt[idx] = tg;
            end
        end
        bus.enable_sign_from_fch   = 1'b0;
        bus.rollback_sign_from_fch = 1'b0;
        bus.finish_sign_from_mem   = 1'b0;
        rdy                        = 1'b1;
    endtask

    initial begin
        logic [31:0] pc;
        int          mode;
        n_cmp = 0;
        n_err = 0;
        clk = 1'b0;
        rst = 1'b1;
        rdy = 1'b1;
        bus.pc_from_fch            = '0;
        bus.enable_sign_from_fch   = 1'b0;
        bus.rollback_sign_from_fch = 1'b0;
        bus.finish_sign_from_mem   = 1'b0;
        bus.inst_block_from_mem    = '0;
        for (int i = 0; i < 32; i++) mv[i] = 1'b0;
        mem[28'h0] = {32'h00B00113, 32'h00A00093, 32'h00000013, 32'h00100073};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fin", bus.finish_sign_to_fch, 0);
        check("rst_inst", bus.inst_to_fch, 0);
        check("rst_mem_en", bus.enable_sign_to_mem, 0);
        check("rst_pc_mem", bus.pc_to_mem, 0);
        rst = 1'b0;

        fetch(32'h0000_0008, 3, 0);   // cold miss, word2 = 0x00A00093
        check("cold_word", bus.inst_to_fch, 32'h00A00093);
        fetch(32'h0000_000C, 1, 0);   // hit, word3 of same block
        check("hit_word", bus.inst_to_fch, 32'h00B00113);
        fetch(32'h0000_0200, 2, 0);   // same index, different tag
        fetch(32'h0000_0000, 0, 0);   // evicted: misses again
        fetch(32'h0000_0040, 2, 1);   // rollback in WAIT_MEM
        fetch(32'h0000_0040, 1, 0);   // line stayed invalid
        fetch(32'h0000_0080, 2, 2);   // rollback coincident with return
        fetch(32'h0000_0080, 0, 0);
        fetch(32'h0000_0100, 0, 3);   // rdy freeze in WAIT_MEM
        fetch(32'h0000_0104, 0, 0);   // hit on the line filled after freeze

        for (int i = 0; i < 60; i++) begin
            pc   = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 4)
                 | $urandom_range(0, 15);
            mode = $urandom_range(0, 5);
            if (mode > 3) mode = 0;
            fetch(pc, $urandom_range(0, 4), mode);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
